// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating tenure counter: cleared when ownership changes, counts while a
// grant is held and sticks at MAX_HOLD-1 so the arbiter can test for preemption.
module mux_arb_hold_cnt #(
    parameter int MAX_HOLD = 4,
    parameter int W        = $clog2(MAX_HOLD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         max_hit
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX_HOLD - 1);

    assign max_hit = (cnt == CNT_MAX);

    // Clear has priority over counting; counting stops at the ceiling.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !max_hit) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Two-requester arbiter driving a downstream 2:1 mux select. Ownership is
// bounded to MAX_HOLD cycles while the other side waits; simultaneous idle
// requests alternate using the last-served flag.
//
//   state   | meaning
//   --------+---------------------------------------------
//   IDLE    | nobody owns the mux, sel holds last value
//   GRANT_A | requester A owns the mux, sel = a
//   GRANT_B | requester B owns the mux, sel = b
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_a,
    input  logic                        req_b,
    input  logic                        done_a,
    input  logic                        done_b,
    output logic                        gnt_a,
    output logic                        gnt_b,
    output logic                        sel,
    output logic [$clog2(MAX_HOLD)-1:0] hold_cnt
);

    localparam int W = $clog2(MAX_HOLD);

    state_t state;
    state_t state_nx;
    logic   last_b;
    logic   max_hit;
    logic   cnt_clr;
    logic   cnt_en;

    // Next-state decode: preemption at the tenure limit beats everything,
    // then a release hands straight over to a waiting requester.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nx = last_b ? GRANT_A : GRANT_B;
                end else if (req_a) begin
                    state_nx = GRANT_A;
                end else if (req_b) begin
                    state_nx = GRANT_B;
                end
            end
            GRANT_A: begin
                if (req_b && max_hit) begin
                    state_nx = GRANT_B;
                end else if (done_a || !req_a) begin
                    state_nx = req_b ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (req_a && max_hit) begin
                    state_nx = GRANT_A;
                end else if (done_b || !req_b) begin
                    state_nx = req_a ? GRANT_A : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The tenure counter restarts on any ownership change and only runs while owned.
    always_comb begin
        cnt_clr = (state_nx != state) || (state == IDLE);
        cnt_en  = (state != IDLE);
    end

    mux_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .W        (W)
    ) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (hold_cnt),
        .max_hit (max_hit)
    );

    // State register with registered grant/select outputs and last-served flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            sel    <= SEL_A;
            last_b <= 1'b1;
        end else begin
            state <= state_nx;
            gnt_a <= (state_nx == GRANT_A);
            gnt_b <= (state_nx == GRANT_B);
            if (state_nx == GRANT_A) begin
                sel    <= SEL_A;
                last_b <= 1'b0;
            end else if (state_nx == GRANT_B) begin
                sel    <= SEL_B;
                last_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: directed scenarios with literal
// expectations, then randomized traffic against a behavioural ownership model.
module tb_mux_arb;

    localparam int MAX_HOLD = 4;
    localparam int HW       = $clog2(MAX_HOLD);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, done_a, done_b;
    logic          gnt_a, gnt_b, sel;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    data_a, data_b, mux_y;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B; tenure counts cycles owned.
    int m_owner = 0;
    int m_cnt   = 0;
    bit m_lastb = 1'b1;
    bit m_sel   = 1'b0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    // Downstream 2:1 mux driven by the arbiter select.
    assign mux_y = sel ? data_b : data_a;

    mux_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .done_a   (done_a),
        .done_b   (done_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .sel      (sel),
        .hold_cnt (hold_cnt)
    );

    function automatic void m_grant(int who);
        m_owner = who;
        m_cnt   = 0;
        m_lastb = (who == 2);
        m_sel   = (who == 2);
    endfunction

    task automatic m_step();
        bit mine_req, mine_done, other_req;
        if (rst) begin
            m_owner = 0; m_cnt = 0; m_lastb = 1'b1; m_sel = 1'b0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        if (m_owner == 0) begin
            if (req_a && req_b)  m_grant(m_lastb ? 1 : 2);
            else if (req_a)      m_grant(1);
            else if (req_b)      m_grant(2);
        end else begin
            mine_req  = (m_owner == 1) ? req_a  : req_b;
            mine_done = (m_owner == 1) ? done_a : done_b;
            other_req = (m_owner == 1) ? req_b  : req_a;
            if (other_req && m_cnt == MAX_HOLD - 1) begin
                m_grant(3 - m_owner);
            end else if (mine_done || !mine_req) begin
                if (other_req) m_grant(3 - m_owner);
                else begin m_owner = 0; m_cnt = 0; end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_cycle();
        if (!m_valid) return;
        n_cmp++;
        if (gnt_a !== (m_owner == 1) || gnt_b !== (m_owner == 2) ||
            sel !== m_sel || hold_cnt !== HW'(m_cnt)) begin
            n_err++;
            $display("FAIL model t=%0t got gnt_a=%b gnt_b=%b sel=%b hold_cnt=%0d want gnt_a=%b gnt_b=%b sel=%b hold_cnt=%0d",
                     $time, gnt_a, gnt_b, sel, hold_cnt, (m_owner == 1), (m_owner == 2), m_sel, m_cnt);
        end
        if (gnt_a || gnt_b) begin
            n_cmp++;
            if ((gnt_a && gnt_b) || mux_y !== (gnt_a ? data_a : data_b)) begin
                n_err++;
                $display("FAIL mux t=%0t got y=%h gnt_a=%b gnt_b=%b want y=%h",
                         $time, mux_y, gnt_a, gnt_b, (gnt_a ? data_a : data_b));
            end
        end
    endtask

    task automatic lit(input string name, input bit ga, input bit gb, input bit s, input int hc);
        n_cmp++;
        if (gnt_a !== ga || gnt_b !== gb || sel !== s || hold_cnt !== HW'(hc)) begin
            n_err++;
            $display("FAIL %s got gnt_a=%b gnt_b=%b sel=%b hold_cnt=%0d want %b %b %b %0d",
                     name, gnt_a, gnt_b, sel, hold_cnt, ga, gb, s, hc);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, check just after the edge.
    task automatic cyc(input bit r, input bit ra, input bit rb, input bit da, input bit db);
        rst    = r;
        req_a  = ra;
        req_b  = rb;
        done_a = da;
        done_b = db;
        data_a = 8'($urandom);
        data_b = 8'($urandom);
        @(posedge clk);
        m_step();
        #1;
        check_cycle();
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        lit("reset", 0, 0, 0, 0);

        // Single requester A for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            lit("solo_a", 1, 0, 0, i);
        end
        cyc(0, 0, 0, 0, 0);
        lit("solo_a_idle", 0, 0, 0, 0);

        // Both requesting from reset: A first, alternate every MAX_HOLD cycles
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 1, 0, 0);
            if ((i / 4) % 2 == 0) lit("alt_a", 1, 0, 0, i % 4);
            else                  lit("alt_b", 0, 1, 1, i % 4);
        end

        // done_a while B waits: direct handover, no idle bubble
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        lit("handover_pre", 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        lit("handover", 0, 1, 1, 0);

        // Long solo A: tenure saturates, no preemption
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 0);
            lit("saturate", 1, 0, 0, (i < 3) ? i : 3);
        end

        // Reset mid-grant of B, then first simultaneous request goes to A
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        lit("b_hold2", 0, 1, 1, 2);
        cyc(1, 0, 1, 0, 0);
        lit("rst_mid", 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        lit("post_rst_a", 1, 0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
